// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM-stage load/store unit. Converts the EX/MEM access fields
//               into a req/ack data-memory transaction, stalls until it ends,
//               and returns aligned, extended load data. A watchdog turns a
//               missing ack into a one-cycle bus-error pulse.
//               Optional: MEM_ALIGN_CHECK_EN adds misalignment detection (ale_o).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_c_in,
    input  logic [31:0] rf_rD2_in,
    input  logic [1:0]  dram_sel_in,
    input  logic [1:0]  addr_mode_in,
    input  logic        sext2_op_in,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] ld_data_o,
    output logic        bus_err_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        ale_o,
`endif
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_off;
    logic [1:0]       r_mode;
    logic             r_sext;

    logic             w_sel_acc;
    logic             w_acc;
    logic             w_timeout;
    logic [1:0]       w_off;
    logic [3:0]       w_wstrb;
    logic [31:0]      w_wdata;
    logic [31:0]      w_shift;
    logic [15:0]      w_half;
    logic [31:0]      w_ld;

    assign w_sel_acc = (dram_sel_in == 2'b01) || (dram_sel_in == 2'b10);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misal;
    assign w_misal = ((addr_mode_in == 2'b01) && alu_c_in[0]) ||
                     (addr_mode_in[1] && (alu_c_in[1:0] != 2'b00));
    assign ale_o   = w_sel_acc && (r_state == c_IDLE) && w_misal;
    assign w_acc   = w_sel_acc && !w_misal;
`else
    assign w_acc   = w_sel_acc;
`endif

    assign stall_o = ((r_state == c_IDLE) && w_acc) || (r_state == c_WAIT);
    assign done_o  = (r_state == c_DONE);

    // Effective lane offset: half ignores addr[0], word always lane 0
    always_comb begin
        w_off   = 2'b00;
        w_wstrb = 4'b1111;
        w_wdata = rf_rD2_in;
        case (addr_mode_in)
            2'b00: begin
                w_off   = alu_c_in[1:0];
                w_wstrb = 4'b0001 << alu_c_in[1:0];
                w_wdata = {4{rf_rD2_in[7:0]}};
            end
            2'b01: begin
                w_off   = {alu_c_in[1], 1'b0};
                w_wstrb = alu_c_in[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rf_rD2_in[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shift = dm_rdata >> {r_off, 3'b000};
    assign w_half  = r_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        w_ld = dm_rdata;
        case (r_mode)
            2'b00:   w_ld = {{24{r_sext & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_ld = {{16{r_sext & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_acc) w_state_nxt = c_WAIT;
            c_WAIT:  if (dm_ack || w_timeout) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= 32'd0;
            dm_wstrb  <= 4'd0;
            dm_wdata  <= 32'd0;
            ld_data_o <= 32'd0;
            bus_err_o <= 1'b0;
            r_cnt     <= '0;
            r_off     <= 2'b00;
            r_mode    <= 2'b00;
            r_sext    <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_acc) begin
                        dm_req   <= 1'b1;
                        dm_we    <= (dram_sel_in == 2'b10);
                        dm_addr  <= {alu_c_in[31:2], 2'b00};
                        dm_wstrb <= (dram_sel_in == 2'b10) ? w_wstrb : 4'b0000;
                        dm_wdata <= w_wdata;
                        r_cnt    <= '0;
                        r_off    <= w_off;
                        r_mode   <= addr_mode_in;
                        r_sext   <= sext2_op_in;
                    end
                end
                c_WAIT: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) ld_data_o <= w_ld;
                    end else if (w_timeout) begin
                        // Abort: a load returns zero rather than stale data
                        dm_req    <= 1'b0;
                        bus_err_o <= 1'b1;
                        if (!dm_we) ld_data_o <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu: directed cases plus
//               randomized accesses against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_c_in, rf_rD2_in, dm_rdata;
    logic [1:0]  dram_sel_in, addr_mode_in;
    logic        sext2_op_in, dm_ack;
    logic        stall_o, done_o, bus_err_o, dm_req, dm_we;
    logic [31:0] ld_data_o, dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
`ifdef MEM_ALIGN_CHECK_EN
    logic        ale_o;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_ld = 32'd0;

    mem_stage_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .alu_c_in(alu_c_in), .rf_rD2_in(rf_rD2_in),
        .dram_sel_in(dram_sel_in), .addr_mode_in(addr_mode_in),
        .sext2_op_in(sext2_op_in),
        .stall_o(stall_o), .done_o(done_o), .ld_data_o(ld_data_o),
        .bus_err_o(bus_err_o),
`ifdef MEM_ALIGN_CHECK_EN
        .ale_o(ale_o),
`endif
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] mode);
        if (mode == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (mode == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] exp_wstrb(input logic [31:0] a, input logic [1:0] mode);
        int off;
        off = int'(a % 4);
        if (mode == 2'b00) return 4'(1 << off);
        if (mode == 2'b01) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] mode, input logic sx);
        int          sh;
        logic [31:0] m, v;
        if (mode == 2'b00) begin
            sh = 8 * int'(a % 4);
            m  = 32'hFF;
        end else if (mode == 2'b01) begin
            sh = (a % 4 >= 2) ? 16 : 0;
            m  = 32'hFFFF;
        end else begin
            return rd;
        end
        v = (rd >> sh) & m;
        if (sx && v > (m >> 1)) v = v - m - 32'd1;
        return v;
    endfunction

    task automatic access(input logic [1:0] sel, input logic [31:0] addr, input logic [31:0] rd2,
                          input logic [1:0] mode, input logic sx, input int ack_at,
                          input logic [31:0] rdata);
        logic is_ld, is_st;
        int   stall_seen;
        is_ld = (sel == 2'b01);
        is_st = (sel == 2'b10);
        dram_sel_in  = sel;
        alu_c_in     = addr;
        rf_rD2_in    = rd2;
        addr_mode_in = mode;
        sext2_op_in  = sx;
        dm_ack       = 1'b0;
        #1;
        if (!(is_ld || is_st)) begin
            chk("idle_stall", stall_o, 1'b0);
            dm_ack   = 1'b1;
            dm_rdata = $urandom;
            step();
            dm_ack = 1'b0;
            chk("idle_req", dm_req, 1'b0);
            chk("idle_done", done_o, 1'b0);
            chk("idle_ld_hold", ld_data_o, model_ld);
            return;
        end
`ifdef MEM_ALIGN_CHECK_EN
        if ((mode == 2'b01 && addr[0]) || (mode[1] && addr % 4 != 0)) begin
            chk("ale_set", ale_o, 1'b1);
            chk("ale_stall", stall_o, 1'b0);
            step();
            chk("ale_req", dm_req, 1'b0);
            chk("ale_ld_hold", ld_data_o, model_ld);
            dram_sel_in = 2'b00;
            return;
        end
        chk("ale_clear", ale_o, 1'b0);
`endif
        chk("issue_stall", stall_o, 1'b1);
        chk("issue_done", done_o, 1'b0);
        stall_seen = int'(stall_o);
        for (int c = 1; c <= TIMEOUT; c++) begin
            step();
            chk("wait_req", dm_req, 1'b1);
            chk("wait_we", dm_we, is_st);
            chk("wait_addr", dm_addr, addr & 32'hFFFF_FFFC);
            chk("wait_wstrb", dm_wstrb, is_st ? exp_wstrb(addr, mode) : 4'h0);
            chk("wait_wdata", dm_wdata, exp_wdata(rd2, mode));
            chk("wait_done", done_o, 1'b0);
            chk("wait_berr", bus_err_o, 1'b0);
            stall_seen += int'(stall_o);
            if (c == ack_at) begin
                dm_ack   = 1'b1;
                dm_rdata = rdata;
                break;
            end
            dm_ack   = 1'b0;
            dm_rdata = $urandom;
        end
        step();
        dm_ack = 1'b0;
        stall_seen += int'(stall_o);
        if (is_ld) model_ld = (ack_at == 0) ? 32'd0 : exp_load(rdata, addr, mode, sx);
        chk("done_flag", done_o, 1'b1);
        chk("done_req", dm_req, 1'b0);
        chk("done_berr", bus_err_o, (ack_at == 0));
        chk("done_ld", ld_data_o, model_ld);
        chk("stall_cycles", 32'(stall_seen), 32'((ack_at == 0) ? TIMEOUT + 1 : ack_at + 1));
        dram_sel_in = 2'b00;
        step();
        chk("after_berr", bus_err_o, 1'b0);
        chk("after_done", done_o, 1'b0);
        chk("after_stall", stall_o, 1'b0);
        chk("after_req", dm_req, 1'b0);
    endtask

    initial begin
        logic [1:0] sel, mode;
        int         r, ack_at;

        rst = 1'b1;
        alu_c_in = 32'd0; rf_rD2_in = 32'd0; dram_sel_in = 2'b00;
        addr_mode_in = 2'b00; sext2_op_in = 1'b0; dm_rdata = 32'd0; dm_ack = 1'b0;
        step();
        step();
        chk("rst_req", dm_req, 1'b0);
        chk("rst_we", dm_we, 1'b0);
        chk("rst_addr", dm_addr, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_wstrb", dm_wstrb, 4'd0);
        chk("rst_ld", ld_data_o, 32'd0);
        chk("rst_berr", bus_err_o, 1'b0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        rst = 1'b0;
        step();

        access(2'b10, 32'h0000_1003, 32'h1234_5678, 2'b00, 1'b0, 1, 32'd0);
        chk("plan_wdata", dm_wdata, 32'h7878_7878);
        chk("plan_wstrb", dm_wstrb, 4'b1000);
        chk("plan_addr", dm_addr, 32'h0000_1000);
        access(2'b01, 32'h0000_2002, 32'd0, 2'b01, 1'b1, 2, 32'h8001_ABCD);
        chk("plan_sh", ld_data_o, 32'hFFFF_8001);
        access(2'b01, 32'h0000_2002, 32'd0, 2'b01, 1'b0, 1, 32'h8001_ABCD);
        chk("plan_uh", ld_data_o, 32'h0000_8001);
        access(2'b10, 32'h0000_2000, 32'hCAFE_0000, 2'b10, 1'b0, 2, 32'd0);
        chk("store_keeps_ld", ld_data_o, 32'h0000_8001);
        access(2'b01, 32'h0000_3000, 32'd0, 2'b10, 1'b1, 3, 32'hDEAD_BEEF);
        chk("plan_word", ld_data_o, 32'hDEAD_BEEF);
        access(2'b01, 32'h0000_3002, 32'd0, 2'b10, 1'b0, 1, 32'h0BAD_F00D);
        access(2'b01, 32'h0000_5001, 32'd0, 2'b00, 1'b1, 0, 32'd0);
        chk("timeout_ld", ld_data_o, 32'd0);
        access(2'b00, 32'h0000_6000, 32'd0, 2'b10, 1'b0, 1, 32'd0);
        access(2'b11, 32'h0000_6000, 32'd0, 2'b10, 1'b0, 1, 32'd0);
        access(2'b01, 32'h0000_7003, 32'd0, 2'b00, 1'b1, 1, 32'h80FF_7F01);
        chk("byte3_sx", ld_data_o, 32'hFFFF_FF80);

        // Reset in the second WAIT cycle, then a stray ack
        dram_sel_in = 2'b01; alu_c_in = 32'h0000_4000; addr_mode_in = 2'b10;
        step();
        step();
        chk("rw_req", dm_req, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rw_req_drop", dm_req, 1'b0);
        chk("rw_ld", ld_data_o, 32'd0);
        chk("rw_done", done_o, 1'b0);
        model_ld    = 32'd0;
        dram_sel_in = 2'b00;
        #1;
        chk("rw_stall", stall_o, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'h1357_9BDF;
        step();
        dm_ack = 1'b0;
        chk("rw_ack_req", dm_req, 1'b0);
        chk("rw_ack_done", done_o, 1'b0);
        chk("rw_ack_ld", ld_data_o, 32'd0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            sel = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            mode = 2'($urandom_range(0, 3));
            ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
            access(sel, $urandom, $urandom, mode, 1'($urandom_range(0, 1)), ack_at, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit, fed directly by the EX/MEM pipeline register. It turns the registered ALU address, store data and memory control fields into a req/ack data-memory transaction. It stalls the pipeline until the transaction completes, then presents aligned, sign/zero-extended load data to the MEM/WB register. A watchdog counter converts a memory that never acks into a one-cycle bus-error pulse.

Parameters:
TIMEOUT, 16, max WAIT cycles without dm_ack before abort (≥2)
CNT_W, 5, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  reset
alu_c_in  in  32  effective address from EX/MEM
rf_rD2_in  in  32  store data from EX/MEM
dram_sel_in  in  2  00 none, 01 load, 10 store, 11 none
addr_mode_in  in  2  00 byte, 01 half, 10/11 word
sext2_op_in  in  1  1 sign-extend load, 0 zero-extend
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
done_o  out  1  access completes this cycle
ld_data_o  out  32  extended load result, to MEM/WB
bus_err_o  out  1  one-cycle pulse on watchdog abort
dm_req  out  1  memory request
dm_we  out  1  1 store, 0 load
dm_addr  out  32  word address {alu_c[31:2],2'b00}
dm_wstrb  out  4  byte-lane write strobes (0 for loads)
dm_wdata  out  32  lane-replicated store data
dm_rdata  in  32  read word, valid with dm_ack
dm_ack  in  1  transaction complete, sampled at posedge

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. Reset forces state=IDLE, dm_req/dm_we=0, dm_addr/dm_wdata/ld_data_o=0, dm_wstrb=0, bus_err_o=0, cnt=0.
- acc = (dram_sel_in==01 || dram_sel_in==10), gated by the alignment check when MEM_ALIGN_CHECK_EN is defined.
- stall_o = (state==IDLE && acc) || state==WAIT. This is combinational.
- done_o = (state==DONE). This is combinational.
- IDLE, acc=1, at the edge:
  - dm_req<=1, dm_we<=(dram_sel==10), dm_addr, dm_wstrb and dm_wdata latched, cnt<=0, state<=WAIT.
  - Byte offset, mode and sext are latched internally.
- WAIT:
  - dm_req, dm_we, dm_addr, dm_wstrb and dm_wdata are held stable.
  - If dm_ack: dm_req<=0, load result written to ld_data_o, state<=DONE.
  - Else if cnt==TIMEOUT-1: dm_req<=0, ld_data_o<=0 on a load, bus_err_o<=1 for one cycle, state<=DONE.
  - Else cnt<=cnt+1.
- DONE: stall_o=0 for exactly one cycle, so upstream advances. Unconditional state<=IDLE. The held instruction is consumed at this edge and is not re-issued.
- Latency: an access presented in cycle 0 and acked in WAIT cycle N gives stall_o high for N+1 cycles and done_o in cycle N+1.
- Store lanes:
  - byte: wdata={4{rD2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - half: wdata={2{rD2[15:0]}}, wstrb=addr[1]?1100:0011.
  - word: wdata=rD2, wstrb=1111.
- Load extract:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - word: whole rdata.
  - Extension per latched sext (sign if 1, zero if 0); word ignores sext.
- ld_data_o holds its value until the next load completes. Stores leave it unchanged.
- dm_ack outside WAIT is ignored.
- Async reset during WAIT drops dm_req immediately; a later ack is ignored.
- dram_sel 00/11: no request, no stall, outputs hold.

Optional Feature:
MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output ale_o (1 bit, combinational) = (half && addr[0]) || (word && addr[1:0]!=0), while dram_sel is a load/store in IDLE.
  - A misaligned access issues no request and does not stall; ld_data_o is unchanged.
- Undefined:
  - No ale_o port.
  - Low address bits are ignored for half/word: half uses addr[1], word uses offset 0.

Test Plan:
- Byte store, alu_c=0x0000_1003, rD2=0x1234_5678, ack in WAIT cycle 1 -> dm_addr=0x1000, wstrb=1000, wdata=0x7878_7878, dm_we=1, stall 2 cycles, done in cycle 2.
- Signed half load at 0x2002, dm_rdata=0x8001_ABCD -> ld_data_o=0xFFFF_8001; same with sext2_op=0 -> 0x0000_8001.
- Word load, ack delayed to WAIT cycle 3, dm_rdata=0xDEAD_BEEF -> stall_o high 4 cycles, dm_addr/dm_req stable throughout, ld_data_o=0xDEAD_BEEF.
- No ack for 16 WAIT cycles -> dm_req drops, bus_err_o pulses once, ld_data_o=0, then IDLE.
- rst asserted in WAIT cycle 2, ack in the following cycle -> dm_req=0 immediately, state IDLE, ld_data_o=0, ack ignored.
- MEM_ALIGN_CHECK_EN defined, word load at 0x3002 -> ale_o=1, dm_req stays 0, stall_o=0; undefined -> dm_addr=0x3000, normal load.
